// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: NCH input channels with valid/ready,
// one registered output stream, plus the runtime select controls.
interface stream_mux_rr_if #(
   parameter int NCH   = 8,
   parameter int WIDTH = 8
);
   localparam int SELW = $clog2(NCH);

   logic                   mode;
   logic [SELW-1:0]        sel;
   logic [NCH*WIDTH-1:0]   in_data;
   logic [NCH-1:0]         in_valid;
   logic [NCH-1:0]         in_ready;
   logic [WIDTH-1:0]       out_data;
   logic [SELW-1:0]        out_ch;
   logic                   out_valid;
   logic                   out_ready;

   modport slave (
      input  mode, sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_ch, out_valid
   );

   modport master (
      output mode, sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_ch, out_valid
   );
endinterface

// File: rtl/stream_mux_rr.sv
// NCH:1 stream multiplexer with fixed or round-robin selection and a single
// registered output stage that sustains one beat per cycle.
module stream_mux_rr #(
   parameter int NCH   = 8,
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   stream_mux_rr_if.slave  bus
);
   localparam int SELW = $clog2(NCH);

   logic [SELW-1:0]  last_q, last_d;
   logic [SELW-1:0]  out_ch_q, out_ch_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;

   logic             load;
   logic             grant_vld;
   logic [SELW-1:0]  grant_idx;
   logic [WIDTH-1:0] grant_data;
   logic [NCH-1:0]   rot;
   logic [NCH-1:0]   in_ready;
   int               rr_off;
   int               rr_sum;

   assign load = ~out_valid_q | bus.out_ready;

   // Rotate valids so bit 0 is the channel just after the last winner.
   assign rot = NCH'({bus.in_valid, bus.in_valid} >> (int'(last_q) + 1));

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      grant_vld  = 1'b0;
      grant_idx  = '0;
      grant_data = '0;
      rr_off     = 0;
      rr_sum     = 0;
      if (!bus.mode) begin
         for (int i = 0; i < NCH; i++) begin
            if (SELW'(i) == bus.sel && bus.in_valid[i]) begin
               grant_vld = 1'b1;
               grant_idx = SELW'(i);
            end
         end
      end else begin
         for (int k = NCH - 1; k >= 0; k--) begin
            if (rot[k]) begin
               grant_vld = 1'b1;
               rr_off    = k;
            end
         end
         rr_sum = int'(last_q) + 1 + rr_off;
         if (rr_sum >= NCH) rr_sum = rr_sum - NCH;
         if (grant_vld) grant_idx = SELW'(rr_sum);
      end
      for (int i = 0; i < NCH; i++) begin
         if (SELW'(i) == grant_idx) grant_data = bus.in_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         in_ready[i] = load & grant_vld & ~rst & (grant_idx == SELW'(i));
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      last_d      = last_q;
      if (load) begin
         out_valid_d = grant_vld;
         if (grant_vld) begin
            out_data_d = grant_data;
            out_ch_d   = grant_idx;
            last_d     = grant_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking <= only; combinational blocks use =.
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         last_q      <= SELW'(NCH - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         last_q      <= last_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr (NCH=8, WIDTH=8): expected beats are
// queued when an input handshake is expected and checked as they leave.
module tb_stream_mux_rr;
   typedef struct packed {
      logic [2:0] ch;
      logic [7:0] data;
   } beat_t;

   logic  clk = 1'b0;
   logic  rst;
   int    n_tests = 0;
   int    n_fail  = 0;
   beat_t sb_q[$];

   stream_mux_rr_if #(.NCH(8), .WIDTH(8)) bus ();

   stream_mux_rr #(.NCH(8), .WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_data(input int ch, input logic [7:0] val);
      bus.in_data[ch*8 +: 8] = val;
   endtask

   // Called right after a negedge with inputs set; ends on the next negedge.
   task automatic drive_cycle(input string tag, input logic [7:0] exp_rdy, input int exp_ov,
                              input bit push, input logic [2:0] ch, input logic [7:0] data);
      beat_t b;
      #1;
      check({tag, "/in_ready"}, bus.in_ready, exp_rdy);
      if (exp_ov >= 0) check({tag, "/out_valid"}, bus.out_valid, exp_ov[0]);
      if (bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            check({tag, "/unexpected_beat"}, sb_q.size(), 1);
         end else begin
            b = sb_q.pop_front();
            check({tag, "/out_ch"}, bus.out_ch, b.ch);
            check({tag, "/out_data"}, bus.out_data, b.data);
         end
      end
      if (push) begin
         b.ch   = ch;
         b.data = data;
         sb_q.push_back(b);
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      check({tag, "/rst_in_ready"}, bus.in_ready, 8'h00);
      @(negedge clk);
      #1;
      check({tag, "/rst_out_valid"}, bus.out_valid, 1'b0);
      check({tag, "/rst_out_data"}, bus.out_data, 8'h00);
      check({tag, "/rst_out_ch"}, bus.out_ch, 3'd0);
      rst = 1'b0;
      sb_q.delete();
   endtask

   initial begin
      rst           = 1'b1;
      bus.mode      = 1'b0;
      bus.sel       = 3'd3;
      bus.in_data   = '0;
      bus.in_valid  = 8'h08;
      bus.out_ready = 1'b1;
      set_data(3, 8'hA5);
      @(negedge clk);

      // Fixed select of ch3 straight out of reset.
      do_reset("t1");
      drive_cycle("t1_xfer", 8'h08, 0, 1'b1, 3'd3, 8'hA5);
      bus.in_valid = 8'h00;
      drive_cycle("t1_out", 8'h00, 1, 1'b0, 3'd0, 8'h00);

      // Round-robin with every channel valid: 0..7,0,1 back to back.
      do_reset("t2");
      for (int i = 0; i < 8; i++) set_data(i, 8'h10 + 8'(i));
      bus.mode     = 1'b1;
      bus.in_valid = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         drive_cycle("t2_rr", 8'h01 << (k % 8), (k == 0) ? 0 : 1, 1'b1,
                     3'(k % 8), 8'h10 + 8'(k % 8));
      end
      bus.in_valid = 8'h00;
      drive_cycle("t2_drain", 8'h00, 1, 1'b0, 3'd0, 8'h00);

      // Sparse round-robin from last=3: ch5, ch2, ch5.
      do_reset("t3");
      bus.mode     = 1'b0;
      bus.sel      = 3'd3;
      bus.in_valid = 8'h08;
      drive_cycle("t3_seed", 8'h08, 0, 1'b1, 3'd3, 8'h13);
      bus.mode     = 1'b1;
      bus.in_valid = 8'h24;
      drive_cycle("t3_g5a", 8'h20, 1, 1'b1, 3'd5, 8'h15);
      drive_cycle("t3_g2",  8'h04, 1, 1'b1, 3'd2, 8'h12);
      drive_cycle("t3_g5b", 8'h20, 1, 1'b1, 3'd5, 8'h15);
      bus.in_valid = 8'h00;
      drive_cycle("t3_drain", 8'h00, 1, 1'b0, 3'd0, 8'h00);

      // Backpressure: held beat stays put, next ch1 beat follows without a bubble.
      bus.mode      = 1'b0;
      bus.sel       = 3'd1;
      bus.in_valid  = 8'h02;
      bus.out_ready = 1'b0;
      set_data(1, 8'h11);
      drive_cycle("t4_load", 8'h02, 0, 1'b1, 3'd1, 8'h11);
      set_data(1, 8'h21);
      for (int k = 0; k < 4; k++) begin
         drive_cycle("t4_stall", 8'h00, 1, 1'b0, 3'd0, 8'h00);
         check("t4_hold_data", bus.out_data, 8'h11);
         check("t4_hold_ch", bus.out_ch, 3'd1);
      end
      bus.out_ready = 1'b1;
      drive_cycle("t4_release", 8'h02, 1, 1'b1, 3'd1, 8'h21);
      bus.in_valid = 8'h00;
      drive_cycle("t4_nobubble", 8'h00, 1, 1'b0, 3'd0, 8'h00);

      // Fixed select pointing at an idle channel grants nothing.
      bus.sel      = 3'd5;
      bus.in_valid = 8'h01;
      set_data(0, 8'h10);
      drive_cycle("t5_nogrant_a", 8'h00, 0, 1'b0, 3'd0, 8'h00);
      drive_cycle("t5_nogrant_b", 8'h00, 0, 1'b0, 3'd0, 8'h00);
      bus.sel = 3'd0;
      drive_cycle("t5_sel0", 8'h01, 0, 1'b1, 3'd0, 8'h10);
      bus.in_valid = 8'h00;
      drive_cycle("t5_drain", 8'h00, 1, 1'b0, 3'd0, 8'h00);

      // Reset with a stalled beat held: beat is discarded, RR restarts at ch0.
      bus.sel       = 3'd2;
      bus.in_valid  = 8'h04;
      bus.out_ready = 1'b0;
      set_data(2, 8'h12);
      drive_cycle("t6_load", 8'h04, 0, 1'b1, 3'd2, 8'h12);
      bus.in_valid = 8'h00;
      drive_cycle("t6_hold", 8'h00, 1, 1'b0, 3'd0, 8'h00);
      bus.mode     = 1'b1;
      bus.in_valid = 8'hFF;
      do_reset("t6");
      bus.out_ready = 1'b1;
      drive_cycle("t6_after", 8'h01, 0, 1'b1, 3'd0, 8'h10);
      bus.in_valid = 8'h00;
      drive_cycle("t6_drain", 8'h00, 1, 1'b0, 3'd0, 8'h00);

      check("sb_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
